mem_port_arbiter: RTL

Arbitrates the CPU's single unified memory port between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage. Each stage presents a hold-until-ack request; the arbiter grants one at a time, drives the memory port from registers, waits on the memory's ack, returns read data to the owner, and pulses that owner's ack. It sits between the pipeline stages and the memory model inside `CPU`; the stages use a missing ack as their stall condition.

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between IF (fetch) and MEM (data)
//                    stages; optional fetch starvation guard via the
//                    MEM_ARB_STARVE_GUARD_EN macro.
// Revision         : 1.0
// ============================================================================

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                owner_q,     owner_d;
  logic                busy_q,      busy_d;
  logic                if_ack_q,    if_ack_d;
  logic                d_ack_q,     d_ack_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

  logic                w_force_fetch;
  logic                w_grant_data;
  logic                w_grant_fetch;

  // Data wins by default: it belongs to the older instruction in the pipe.
  assign w_grant_data  = d_req && !w_force_fetch;
  assign w_grant_fetch = if_req && !w_grant_data;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  assign w_force_fetch = if_req && (starve_q == C_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Counts data grants taken while a fetch is waiting; any fetch grant or a
  // quiet fetch side in IDLE restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (!if_req || w_grant_fetch) begin
        starve_d = '0;
      end else if (w_grant_data) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end
`else
  logic w_unused_limit;

  assign w_force_fetch  = 1'b0;
  assign w_unused_limit = (STARVE_LIMIT != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    if_ack_d    = if_ack_q;
    d_ack_d     = d_ack_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (w_grant_data || w_grant_fetch) begin
          state_d     = S_BUSY;
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
          owner_d     = w_grant_data;
          mem_addr_d  = w_grant_data ? d_addr : if_addr;
          mem_we_d    = w_grant_data && d_we;
          mem_wdata_d = w_grant_data ? d_wdata : '0;
        end
      end

      S_BUSY: begin
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (owner_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end

      // The ack pulse lives only here, so the following IDLE cycle never
      // re-arbitrates a request in the same cycle it is being acked.
      S_DONE: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        if_ack_d = 1'b0;
        d_ack_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

`default_nettype wire
